prbs_seq_ctrl: RTL and testbench

- Sequencer for a pseudo-random bit-pattern link test built on an N-bit XNOR-feedback LFSR: feedback = lfsr[N] XNOR lfsr[FB_TAP], shifted in at bit 1.
- Seeds a transmit LFSR, emits a burst of LEN bits, then checks the returned bit stream against a second, lock-stepped LFSR.
- Counts mismatches and reports pass/fail/timeout to the JTAG-side register logic.
- Sits between the JTAG user-register block and the loopback path under test.

---
 rtl/prbs_seq_ctrl_pkg.sv | 17 +
 rtl/prbs_seq_ctrl_lfsr_core.sv | 33 +++
 rtl/prbs_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_prbs_seq_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_seq_ctrl_pkg.sv
// Shared types for the PRBS link-test sequencer: FSM state encoding and the
// XNOR feedback primitive used by both pattern generators.
package prbs_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_WAIT = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  function automatic logic xnor_fb(input logic a, input logic b);
    return ~(a ^ b);
  endfunction

endpackage

// File: rtl/prbs_seq_ctrl_lfsr_core.sv
// XNOR-feedback LFSR, bits numbered N..1, feedback shifted in at bit 1.
// All-ones is the lockup state; the caller keeps it out of the seed.
module prbs_lfsr_core
  import prbs_seq_ctrl_pkg::*;
#(
  parameter int N      = 15,
  parameter int FB_TAP = 14
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [N:1]   i_seed,
  input  logic         i_shift,
  output logic         o_msb
);

  logic [N:1] r_lfsr;
  logic       w_fb;

  assign w_fb  = xnor_fb(r_lfsr[N], r_lfsr[FB_TAP]);
  assign o_msb = r_lfsr[N];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_lfsr <= '0;
    end else if (i_load) begin
      r_lfsr <= i_seed;
    end else if (i_shift) begin
      r_lfsr <= {r_lfsr[N-1:1], w_fb};
    end
  end

endmodule

// File: rtl/prbs_seq_ctrl.sv
// PRBS link-test sequencer: seeds tx/rx pattern generators, emits a burst,
// checks the returned stream and reports pass/fail/timeout.
//
// state | meaning
// IDLE  | waiting for START; results held
// LOAD  | generators seeded, counters cleared
// RUN   | emitting LEN pattern bits, checker active
// WAIT  | burst sent, checking remaining bits under timeout
// FIN   | one-cycle DONE with PASS/TIMED_OUT valid
module prbs_seq_ctrl
  import prbs_seq_ctrl_pkg::*;
#(
  parameter int N      = 15,
  parameter int FB_TAP = 14,
  parameter int LEN_W  = 16,
  parameter int ERR_W  = 16,
  parameter int TO_W   = 12
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             ABORT,
  input  logic [N-1:0]     SEED,
  input  logic [LEN_W-1:0] LEN,
  input  logic [TO_W-1:0]  TIMEOUT,
  output logic             TX_BIT,
  output logic             TX_VALID,
  input  logic             RX_BIT,
  input  logic             RX_VALID,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic             TIMED_OUT,
  output logic             SEED_BAD,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [LEN_W-1:0] RX_CNT
);

  state_t           r_state, w_state_nxt;
  logic [LEN_W-1:0] r_tx_cnt, r_rx_cnt, w_rx_cnt_nxt;
  logic [ERR_W-1:0] r_err_cnt, w_err_cnt_nxt;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_pass, r_timed_out, r_seed_bad;
  logic             w_start, w_abort, w_rx_acc, w_tx_last, w_rx_full, w_to_fin;
  logic             w_tx_msb, w_rx_msb, w_tx_shift;
  logic [N:1]       w_seed_eff;
  logic             w_tx_valid, w_busy, w_done;

  assign w_start    = (r_state == ST_IDLE) & START & ~ABORT;
  assign w_abort    = ABORT & (r_state != ST_IDLE);
  assign w_tx_shift = (r_state == ST_RUN) & ~w_abort;
  // An all-ones seed would lock the generators, so substitute zero.
  assign w_seed_eff = (&SEED) ? '0 : SEED;

  assign w_rx_acc = ((r_state == ST_RUN) | (r_state == ST_WAIT)) & RX_VALID
                    & (r_rx_cnt < LEN) & ~w_abort;
  assign w_rx_cnt_nxt  = r_rx_cnt + LEN_W'(w_rx_acc);
  assign w_err_cnt_nxt = (w_rx_acc & (RX_BIT ^ w_rx_msb) & ~(&r_err_cnt))
                         ? r_err_cnt + ERR_W'(1) : r_err_cnt;
  assign w_tx_last = (r_tx_cnt == LEN - LEN_W'(1));
  assign w_rx_full = (w_rx_cnt_nxt == LEN);
  // Completion has priority over an expiring timeout in the same cycle.
  assign w_to_fin  = (r_state == ST_WAIT) & ~w_rx_acc & (r_to_cnt == TIMEOUT) & ~w_rx_full;

  prbs_lfsr_core #(.N(N), .FB_TAP(FB_TAP)) u_tx_lfsr (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_load  (w_start),
    .i_seed  (w_seed_eff),
    .i_shift (w_tx_shift),
    .o_msb   (w_tx_msb)
  );

  prbs_lfsr_core #(.N(N), .FB_TAP(FB_TAP)) u_rx_lfsr (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_load  (w_start),
    .i_seed  (w_seed_eff),
    .i_shift (w_rx_acc),
    .o_msb   (w_rx_msb)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_tx_valid  = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (w_start) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: w_state_nxt = (LEN == '0) ? ST_FIN : ST_RUN;
      ST_RUN: begin
        w_tx_valid = 1'b1;
        if (w_tx_last) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: if (w_rx_full || w_to_fin) w_state_nxt = ST_FIN;
      ST_FIN: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_abort) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_tx_cnt    <= '0;
      r_rx_cnt    <= '0;
      r_err_cnt   <= '0;
      r_to_cnt    <= '0;
      r_pass      <= 1'b0;
      r_timed_out <= 1'b0;
      r_seed_bad  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_tx_cnt    <= '0;
        r_rx_cnt    <= '0;
        r_err_cnt   <= '0;
        r_to_cnt    <= '0;
        r_pass      <= 1'b0;
        r_timed_out <= 1'b0;
        r_seed_bad  <= &SEED;
      end else if (w_abort) begin
        r_pass      <= 1'b0;
        r_timed_out <= 1'b0;
      end else begin
        if (r_state == ST_RUN) r_tx_cnt <= r_tx_cnt + LEN_W'(1);
        r_rx_cnt  <= w_rx_cnt_nxt;
        r_err_cnt <= w_err_cnt_nxt;
        if (r_state == ST_WAIT) r_to_cnt <= w_rx_acc ? '0 : r_to_cnt + TO_W'(1);
        // Result is registered on FIN entry so it lines up with DONE.
        if (w_state_nxt == ST_FIN) begin
          r_timed_out <= w_to_fin;
          r_pass      <= (w_err_cnt_nxt == '0) & w_rx_full & ~w_to_fin;
        end
      end
    end
  end

  assign TX_VALID  = w_tx_valid;
  assign TX_BIT    = w_tx_valid & w_tx_msb;
  assign BUSY      = w_busy;
  assign DONE      = w_done;
  assign PASS      = r_pass;
  assign TIMED_OUT = r_timed_out;
  assign SEED_BAD  = r_seed_bad;
  assign ERR_CNT   = r_err_cnt;
  assign RX_CNT    = r_rx_cnt;

endmodule

// File: tb/tb_prbs_seq_ctrl.sv
// Bench for prbs_seq_ctrl (N=3, FB_TAP=2, ERR_W=2): looped-back bursts checked
// against a burst-level model of the pattern, checker and timeout rules.
module tb_prbs_seq_ctrl;

  localparam int TN = 3, TTAP = 2, TLW = 8, TEW = 2, TTW = 4;

  logic           CLK = 1'b0;
  logic           RST_N, START, ABORT, RX_BIT, RX_VALID;
  logic [TN-1:0]  SEED;
  logic [TLW-1:0] LEN;
  logic [TTW-1:0] TIMEOUT;
  logic           TX_BIT, TX_VALID, BUSY, DONE, PASS, TIMED_OUT, SEED_BAD;
  logic [TEW-1:0] ERR_CNT;
  logic [TLW-1:0] RX_CNT;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  prbs_seq_ctrl #(.N(TN), .FB_TAP(TTAP), .LEN_W(TLW), .ERR_W(TEW), .TO_W(TTW)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT), .SEED(SEED), .LEN(LEN),
    .TIMEOUT(TIMEOUT), .TX_BIT(TX_BIT), .TX_VALID(TX_VALID), .RX_BIT(RX_BIT),
    .RX_VALID(RX_VALID), .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .TIMED_OUT(TIMED_OUT),
    .SEED_BAD(SEED_BAD), .ERR_CNT(ERR_CNT), .RX_CNT(RX_CNT)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    vectors++;
    assert (obs === expd) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expd);
    end
  endtask

  function automatic int lfsr_next(input int s);
    int msb, tap;
    msb = (s >> (TN - 1)) & 1;
    tap = (s >> (TTAP - 1)) & 1;
    return ((s << 1) & ((1 << TN) - 1)) | (1 - (msb ^ tap));
  endfunction

  // One burst: START at cycle 0 edge, cycle k = k-th cycle after that edge.
  task automatic run_case(input string nm, input int seed, input int len, input int tmo,
                          input int dly, input logic [31:0] flips, input int n_ret,
                          input int abort_at, input int rst_at, input bit start_in_run,
                          output logic [31:0] tx_pk, output logic [31:0] err_o,
                          output logic [31:0] pass_o, output logic [31:0] to_o);
    int q[$];
    int offer_cyc[$];
    int offer_bit[$];
    int exp_bits[$];
    int tx_bits[$];
    int k, ret, done_n, done_k, tx_first, v, b, s;
    int fin, acc, err, to, idle, oi, errmax, n_pre;
    bit stop, offered, accepted, idle_ok;
    logic [31:0] pass_d, to_d, bad_d, err_d, rx_d, exp_pk;

    tx_pk = 0; err_o = 0; pass_o = 0; to_o = 0;
    pass_d = 0; to_d = 0; bad_d = 0; err_d = 0; rx_d = 0;
    s = (seed == (1 << TN) - 1) ? 0 : seed;
    for (int i = 0; i < len; i++) begin
      exp_bits.push_back((s >> (TN - 1)) & 1);
      s = lfsr_next(s);
    end

    @(negedge CLK);
    SEED = TN'(seed); LEN = TLW'(len); TIMEOUT = TTW'(tmo);
    START = 1'b1; ABORT = 1'b0; RX_VALID = 1'b0;
    k = 0; ret = 0; done_n = 0; done_k = -1; tx_first = -1; stop = 0;
    while (!stop) begin
      @(negedge CLK);
      k++;
      START = start_in_run && (k == 3);
      if (TX_VALID === 1'b1) begin
        if (tx_first < 0) tx_first = k;
        tx_bits.push_back(int'(TX_BIT));
      end
      if (DONE === 1'b1) begin
        done_n++; done_k = k;
        pass_d = 32'(PASS); to_d = 32'(TIMED_OUT); bad_d = 32'(SEED_BAD);
        err_d = 32'(ERR_CNT); rx_d = 32'(RX_CNT);
      end
      if (k == 1) chk($sformatf("%s.busy_load", nm), 32'(BUSY), 1);
      // loopback delay line
      q.push_back((TX_VALID === 1'b1) ? 2 + int'(TX_BIT) : 0);
      RX_VALID = 1'b0;
      RX_BIT = 1'($urandom_range(0, 1));
      if (q.size() > dly) begin
        v = q.pop_front();
        if (v >= 2 && ret < n_ret) begin
          b = (v & 1) ^ ((ret < 32) ? int'(flips[ret]) : 0);
          RX_VALID = 1'b1; RX_BIT = 1'(b);
          offer_cyc.push_back(k); offer_bit.push_back(b);
          ret++;
        end
      end
      if (abort_at > 0 && k == abort_at) ABORT = 1'b1;
      if (abort_at > 0 && k == abort_at + 1) begin
        ABORT = 1'b0; RX_VALID = 1'b0;
        n_pre = 0;
        foreach (offer_cyc[i]) if (offer_cyc[i] < abort_at) n_pre++;
        exp_pk = 0; tx_pk = 0;
        for (int i = 0; i < abort_at - 1 && i < len; i++) exp_pk |= 32'(exp_bits[i]) << i;
        foreach (tx_bits[i]) tx_pk |= 32'(tx_bits[i]) << i;
        chk($sformatf("%s.tx_valid", nm), 32'(TX_VALID), 0);
        chk($sformatf("%s.busy", nm), 32'(BUSY), 0);
        chk($sformatf("%s.pass", nm), 32'(PASS), 0);
        chk($sformatf("%s.timed_out", nm), 32'(TIMED_OUT), 0);
        chk($sformatf("%s.tx_count", nm), tx_bits.size(), abort_at - 1);
        chk($sformatf("%s.tx_stream", nm), tx_pk, exp_pk);
        chk($sformatf("%s.rx_cnt", nm), 32'(RX_CNT), n_pre);
        chk($sformatf("%s.done_count", nm), done_n, 0);
        idle_ok = 1;
        for (int j = 0; j < 3; j++) begin
          @(negedge CLK);
          if (BUSY !== 1'b0 || DONE !== 1'b0 || TX_VALID !== 1'b0) idle_ok = 0;
        end
        chk($sformatf("%s.idle_after", nm), 32'(idle_ok), 1);
        stop = 1;
      end
      if (rst_at > 0 && k == rst_at) RST_N = 1'b0;
      if (rst_at > 0 && k == rst_at + 1) begin
        chk($sformatf("%s.outputs_zero", nm),
            32'({TX_BIT, TX_VALID, BUSY, DONE, PASS, TIMED_OUT, SEED_BAD, ERR_CNT, RX_CNT}), 0);
        RST_N = 1'b1; RX_VALID = 1'b0;
        stop = 1;
      end
      if (done_n > 0 && k == done_k + 1) begin
        chk($sformatf("%s.busy_after", nm), 32'(BUSY), 0);
        chk($sformatf("%s.pass_held", nm), 32'(PASS), pass_d);
        stop = 1;
      end
      if (!stop && k >= 300) begin
        chk($sformatf("%s.finished", nm), done_n, 1);
        stop = 1;
      end
    end
    START = 1'b0; ABORT = 1'b0; RX_VALID = 1'b0;
    if (abort_at > 0 || rst_at > 0) return;

    // burst-level reference outcome
    fin = -1; acc = 0; err = 0; to = 0; idle = 0; oi = 0;
    errmax = (1 << TEW) - 1;
    if (len == 0) begin
      fin = 2;
    end else begin
      for (int t = 2; fin < 0 && t < len + 80; t++) begin
        offered  = (oi < offer_cyc.size()) && (offer_cyc[oi] == t);
        accepted = offered && (acc < len);
        if (accepted) begin
          if (offer_bit[oi] != exp_bits[acc]) err = (err < errmax) ? err + 1 : err;
          acc++;
        end
        if (offered) oi++;
        if (t >= 2 + len) begin
          if (acc == len) fin = t + 1;
          else if (accepted) idle = 0;
          else if (idle == tmo) begin fin = t + 1; to = 1; end
          else idle++;
        end
      end
    end

    exp_pk = 0; tx_pk = 0;
    for (int i = 0; i < len; i++) exp_pk |= 32'(exp_bits[i]) << i;
    foreach (tx_bits[i]) tx_pk |= 32'(tx_bits[i]) << i;
    chk($sformatf("%s.done_count", nm), done_n, 1);
    chk($sformatf("%s.done_cycle", nm), done_k, fin);
    chk($sformatf("%s.tx_count", nm), tx_bits.size(), len);
    chk($sformatf("%s.tx_stream", nm), tx_pk, exp_pk);
    if (len > 0) chk($sformatf("%s.tx_first", nm), tx_first, 2);
    chk($sformatf("%s.rx_cnt", nm), rx_d, acc);
    chk($sformatf("%s.err_cnt", nm), err_d, err);
    chk($sformatf("%s.timed_out", nm), to_d, to);
    chk($sformatf("%s.pass", nm), pass_d, (err == 0 && to == 0 && acc == len) ? 1 : 0);
    chk($sformatf("%s.seed_bad", nm), bad_d, (seed == (1 << TN) - 1) ? 1 : 0);
    err_o = err_d; pass_o = pass_d; to_o = to_d;
  endtask

  initial begin
    logic [31:0] pk, e, p, t;
    int r_len, r_nret;
    RST_N = 1'b0; START = 1'b0; ABORT = 1'b0; SEED = '0; LEN = '0; TIMEOUT = '0;
    RX_BIT = 1'b0; RX_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_outputs",
        32'({TX_BIT, TX_VALID, BUSY, DONE, PASS, TIMED_OUT, SEED_BAD, ERR_CNT, RX_CNT}), 0);
    RST_N = 1'b1;

    @(negedge CLK);
    START = 1'b1; ABORT = 1'b1; SEED = 3'd2; LEN = 8'd7;
    @(negedge CLK);
    START = 1'b0; ABORT = 1'b0;
    chk("idle_abort_blocks_start", 32'(BUSY), 0);

    run_case("seed0", 0, 7, 15, 3, 32'h0, 7, 0, 0, 0, pk, e, p, t);
    chk("seed0.pattern", pk, 32'h58);
    chk("seed0.pass_direct", p, 1);

    run_case("flip4", 0, 7, 15, 3, 32'h8, 7, 0, 0, 0, pk, e, p, t);
    chk("flip4.err_direct", e, 1);
    chk("flip4.pass_direct", p, 0);

    run_case("timeout", 0, 7, 5, 3, 32'h0, 4, 0, 0, 0, pk, e, p, t);
    chk("timeout.flag_direct", t, 1);

    run_case("seed_ones", 7, 7, 15, 3, 32'h0, 7, 0, 0, 0, pk, e, p, t);
    chk("seed_ones.pattern", pk, 32'h58);

    run_case("abort", 0, 7, 15, 3, 32'h0, 7, 4, 0, 1, pk, e, p, t);

    run_case("len0", 5, 0, 3, 3, 32'h0, 0, 0, 0, 0, pk, e, p, t);
    chk("len0.pass_direct", p, 1);

    run_case("err_sat", 0, 7, 15, 2, 32'h7f, 7, 0, 0, 0, pk, e, p, t);
    chk("err_sat.err_direct", e, 3);

    run_case("tmo0", 3, 3, 0, 5, 32'h0, 3, 0, 0, 0, pk, e, p, t);

    run_case("rst_wait", 0, 7, 15, 3, 32'h0, 2, 0, 11, 0, pk, e, p, t);

    for (int i = 0; i < 14; i++) begin
      r_len  = $urandom_range(0, 20);
      r_nret = ($urandom_range(0, 3) == 0) ? $urandom_range(0, r_len) : r_len;
      run_case($sformatf("rnd%0d", i), $urandom_range(0, 7), r_len, $urandom_range(0, 6),
               $urandom_range(0, 5), $urandom & $urandom & $urandom, r_nret, 0, 0,
               1'($urandom_range(0, 1)), pk, e, p, t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
